anyedge_order_checker: RTL
==========================

Name: anyedge_order_checker

Overview:
- Synchronous consumer stage for a two-flag handshake. It watches `flag_a` for any edge, rising or falling.
- On each accepted edge it checks that `flag_b` is 0 at detection, and that `flag_b` is 1 exactly `POST_DELAY` cycles later.
- It reports per-event pass/fail pulses, sticky error flags and saturating counters.
- It sits directly downstream of the flag-producing sequencer and turns its timing contract into checkable hardware status.

Parameters:
- POST_DELAY, 2, cycles from edge detection to post-check; legal range ≥1.
- HOLDOFF, 4, cycles after the post-check during which new edges are not accepted; legal range ≥0.
- CNT_W, 8, width of `event_count`, `err_count` and `overlap_count`.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  arm; edges are accepted only while `en`=1 in IDLE.
- clear  in  1  synchronous clear of sticky flags and counters.
- flag_a  in  1  watched signal; already synchronous to `clk`.
- flag_b  in  1  checked signal; already synchronous to `clk`.
- busy  out  1  high in WAIT or HOLD.
- chk_valid  out  1  one-cycle pulse: a post-check has completed.
- chk_pass  out  1  valid with `chk_valid`; 1 when both pre-check and post-check passed.
- err_pre  out  1  sticky: `flag_b` was not 0 at an accepted edge.
- err_post  out  1  sticky: `flag_b` was not 1 at the post-check.
- event_count  out  CNT_W  accepted edges, saturating.
- err_count  out  CNT_W  failed checks, saturating; pre and post failures each count 1.
- overlap_count  out  CNT_W  edges seen in WAIT or HOLD and discarded, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; `flag_a_q`=0; delay counter=0.
  - All outputs are 0.
- Edge detection: `edge` = (`flag_a` != `flag_a_q`), evaluated at each rising clk edge. `flag_a_q` <= `flag_a` every cycle in every state.
- IDLE:
  - Condition: `edge` && `en` at clock edge k.
  - Pre-check samples `flag_b` at edge k. If `flag_b` != 0: set `err_pre`, increment `err_count`, latch pre_fail.
  - Increment `event_count`; load counter with POST_DELAY-1; go to WAIT.
  - `edge` with `en`=0: ignored, no counting.
- WAIT:
  - Counter decrements each cycle. When the counter reaches 0 (clock edge k+POST_DELAY), post-check samples `flag_b`.
  - If `flag_b` != 1: set `err_post` and increment `err_count`.
  - Registered outputs: `chk_valid`=1 for exactly one cycle after edge k+POST_DELAY. `chk_pass` = !pre_fail && post ok.
  - Next state: HOLD with counter=HOLDOFF-1, or IDLE directly if HOLDOFF=0.
- HOLD:
  - Counter decrements; go to IDLE when it reaches 0.
  - Result: a new edge can be accepted no earlier than clock edge k+POST_DELAY+HOLDOFF+1.
- Edges in WAIT or HOLD: increment `overlap_count`; no restart, no check.
- `en` dropping mid-check: the in-flight check completes normally.
- `clear`=1:
  - Zeroes `err_pre`, `err_post` and all counters. It wins over a simultaneous increment or set.
  - It does not affect state, `chk_valid` or `chk_pass`.
- Counters saturate at 2^CNT_W-1 and never wrap.
- The post-check uses the `flag_b` sample at edge k+POST_DELAY only; `flag_b` glitches between checks are not observed.
- Reset asserted in WAIT or HOLD aborts the check immediately; no `chk_valid` is produced. After release, `flag_a_q`=0, so `flag_a`=1 registers as an edge.
- `chk_valid` and `chk_pass` are 0 whenever `chk_valid` is not pulsing.

Decomposition:
- Package `anyedge_pkg`:
  - State enum `chk_state_e` {IDLE, WAIT, HOLD}.
  - Localparam helper for counter width: $clog2(max(POST_DELAY,HOLDOFF)+1), minimum 1.
  - Typedef `cnt_t` for the saturating counters.
- One sub-module: `edge_detect_any` (registers `flag_a`, outputs `edge`; async active-low reset to 0).
- Saturating increment as a package function.

Test Plan (POST_DELAY=2, HOLDOFF=4, CNT_W=8 unless stated):
1. `flag_b`=0, `flag_a` 0→1 at edge 10, `flag_b`→1 at edge 11 -> `chk_valid`=1 and `chk_pass`=1 after edge 12; `event_count`=1; `err_count`=0; `busy` falls after edge 16.
2. `flag_b`=1 at the accepted edge, then held at 1 -> `err_pre`=1, `err_count`=1, `chk_pass`=0, `err_post`=0.
3. `flag_b` held at 0 throughout, `flag_a` 1→0 (falling edge) -> edge accepted; `err_post`=1, `err_count`=1, `chk_pass`=0.
4. Toggle `flag_a` at edges 10, 11, 14 -> only edge 10 is checked; `overlap_count`=2; `event_count`=1; a toggle at edge 17 is accepted.
5. Assert `rst_n`=0 one cycle after acceptance -> no `chk_valid` pulse; all outputs 0. With `flag_a`=1 after release, an edge is accepted on the first clock.
6. Drive `err_count` to 255 with CNT_W=8, then one more failure -> `err_count` stays 255. Assert `clear` on a failing check cycle -> `err_count`=0 and `err_pre`/`err_post`=0 in the following cycle.

Source files
------------

// File: rtl/anyedge_pkg.sv
// anyedge_pkg
// Shared types and helpers for the any-edge order checker.
//   chk_state_e : checker FSM states
//   cnt_t       : widest supported status counter (CNT_W must not exceed it)
//   cnt_width() : width of the shared delay/holdoff down-counter
//   sat_inc()   : saturating increment, clamped at 2^width-1
package anyedge_pkg;

   localparam int CNT_W_MAX = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      WAIT = ST_WAIT,
      HOLD = ST_HOLD
   } chk_state_e;

   typedef logic [CNT_W_MAX-1:0] cnt_t;

   // One counter serves both the post-check delay and the holdoff, so it
   // must hold the larger of the two load values; never narrower than 1 bit.
   function automatic int cnt_width(input int post_delay, input int holdoff);
      int m;
      int w;
      m = (post_delay > holdoff) ? post_delay : holdoff;
      w = $clog2(m + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // At width == CNT_W_MAX the shift wraps to 0 and the -1 gives all ones,
   // so the full-width case still saturates correctly.
   function automatic cnt_t sat_inc(input cnt_t val, input int width);
      cnt_t max_val;
      max_val = (cnt_t'(1) << width) - cnt_t'(1);
      return (val >= max_val) ? val : val + cnt_t'(1);
   endfunction

endpackage

// File: rtl/anyedge_order_checker_edge_detect_any.sv
// edge_detect_any
// Registers a signal that is already synchronous to clk and flags any
// change (rising or falling) against the registered copy.
//   clk      : clock
//   rst_n    : asynchronous active-low reset, clears the registered copy
//   sig      : watched signal
//   any_edge : sig differs from its value at the previous clock edge
module edge_detect_any (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic any_edge
);

   logic sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig;
      end
   end

   // After reset sig_q is 0, so a sig held high reads as an edge.
   assign any_edge = (sig != sig_q);

endmodule

// File: rtl/anyedge_order_checker.sv
// anyedge_order_checker
// Watches flag_a for any edge; for each accepted edge checks that flag_b is
// low at the edge and high POST_DELAY cycles later, then ignores new edges
// for HOLDOFF cycles. Reports per-check pulses, sticky errors and
// saturating counters.
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : arm; edges accepted only in IDLE while en=1
//   clear          : synchronous clear of sticky flags and counters
//   flag_a, flag_b : watched / checked flags, synchronous to clk
//   busy           : check or holdoff in progress
//   chk_valid      : one-cycle pulse when a post-check completes
//   chk_pass       : with chk_valid, both pre- and post-check passed
//   err_pre        : sticky, flag_b was high at an accepted edge
//   err_post       : sticky, flag_b was low at a post-check
//   event_count    : accepted edges (saturating)
//   err_count      : failed checks (saturating)
//   overlap_count  : edges discarded while busy (saturating)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for an edge on flag_a while en=1
// WAIT  | edge accepted, counting down to the post-check
// HOLD  | post-check done, counting down the holdoff window
module anyedge_order_checker
   import anyedge_pkg::*;
#(
   parameter int POST_DELAY = 2,
   parameter int HOLDOFF    = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic             flag_a,
   input  logic             flag_b,
   output logic             busy,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic             err_pre,
   output logic             err_post,
   output logic [CNT_W-1:0] event_count,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] overlap_count
);

   localparam int CW = cnt_width(POST_DELAY, HOLDOFF);
   localparam logic [CW-1:0] WAIT_LOAD = CW'(POST_DELAY - 1);
   localparam logic [CW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

   chk_state_e    state;
   logic [CW-1:0] cnt;
   logic          pre_fail;
   logic          any_edge;

   logic accept;
   logic post_now;
   logic pre_err;
   logic post_err;
   logic overlap;

   edge_detect_any u_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig      (flag_a),
      .any_edge (any_edge)
   );

   assign accept   = (state == IDLE) && any_edge && en;
   assign post_now = (state == WAIT) && (cnt == '0);
   assign pre_err  = accept && flag_b;
   assign post_err = post_now && !flag_b;
   assign overlap  = any_edge && (state != IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         pre_fail <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= WAIT;
                  cnt      <= WAIT_LOAD;
                  pre_fail <= flag_b;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  if (HOLDOFF == 0) begin
                     state <= IDLE;
                  end else begin
                     state <= HOLD;
                     cnt   <= HOLD_LOAD;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Result pulse; clear deliberately leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_valid <= 1'b0;
         chk_pass  <= 1'b0;
      end else begin
         chk_valid <= post_now;
         chk_pass  <= post_now && !pre_fail && flag_b;
      end
   end

   // Pre- and post-errors fall in different cycles, so err_count never
   // needs to advance by two at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pre       <= 1'b0;
         err_post      <= 1'b0;
         event_count   <= '0;
         err_count     <= '0;
         overlap_count <= '0;
      end else if (clear) begin
         err_pre       <= 1'b0;
         err_post      <= 1'b0;
         event_count   <= '0;
         err_count     <= '0;
         overlap_count <= '0;
      end else begin
         if (pre_err) begin
            err_pre <= 1'b1;
         end
         if (post_err) begin
            err_post <= 1'b1;
         end
         if (accept) begin
            event_count <= CNT_W'(sat_inc(cnt_t'(event_count), CNT_W));
         end
         if (pre_err || post_err) begin
            err_count <= CNT_W'(sat_inc(cnt_t'(err_count), CNT_W));
         end
         if (overlap) begin
            overlap_count <= CNT_W'(sat_inc(cnt_t'(overlap_count), CNT_W));
         end
      end
   end

endmodule
